multiplexor_afisaj: RTL and testbench

Time-multiplexed scanner for a 4-digit common-anode 7-segment display. Captures four BCD digits, cycles through them at a programmable refresh rate, and presents one digit at a time to the BCD-to-7-segment decoder together with the matching active-low anode enable. Optional leading-zero blanking drives the decoder's blank code, 4'hF.

---
 rtl/multiplexor_afisaj_if.sv | 27 ++
 rtl/multiplexor_afisaj.sv | 61 ++++++
 tb/tb_multiplexor_afisaj.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/multiplexor_afisaj_if.sv
// rtl/multiplexor_afisaj_if.sv - capture/blanking inputs and scanned digit outputs of the display scanner
interface multiplexor_afisaj_if;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [3:0]  digit_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    modport master (
        output load,
        output bcd_in,
        output blank_lz,
        input  digit_out,
        input  an,
        input  digit_idx
    );

    modport slave (
        input  load,
        input  bcd_in,
        input  blank_lz,
        output digit_out,
        output an,
        output digit_idx
    );
endinterface

// File: rtl/multiplexor_afisaj.sv
// rtl/multiplexor_afisaj.sv - 4-digit multiplexed 7-segment scanner with leading-zero blanking
module multiplexor_afisaj #(
    parameter int DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    multiplexor_afisaj_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [15:0]   cap;
    logic [PW-1:0] presc;
    logic [1:0]    idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap <= 16'h0000;
        end else if (bus.load) begin
            cap <= bus.bcd_in;
        end
    end

    // Prescaler wrap is the only event that moves the scan; load never touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    logic zero3, zero2, zero1;
    logic blank;
    logic [3:0] nibble;

    // Digit k is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        zero3  = (cap[15:12] == 4'h0);
        zero2  = zero3 && (cap[11:8] == 4'h0);
        zero1  = zero2 && (cap[7:4] == 4'h0);
        nibble = cap[idx*4 +: 4];
        blank  = 1'b0;
        if (bus.blank_lz) begin
            case (idx)
                2'd1:    blank = zero1;
                2'd2:    blank = zero2;
                2'd3:    blank = zero3;
                default: blank = 1'b0;
            endcase
        end
    end

    assign bus.digit_idx = idx;
    assign bus.an        = ~(4'b0001 << idx);
    assign bus.digit_out = blank ? 4'hF : nibble;
endmodule

// File: tb/tb_multiplexor_afisaj.sv
// tb/tb_multiplexor_afisaj.sv - randomized and directed bench for multiplexor_afisaj against a cycle-count model
module tb_multiplexor_afisaj;
    localparam int DIV = 4;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] m_cap;
    int          m_t;

    multiplexor_afisaj_if bus ();

    multiplexor_afisaj #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int exp_idx();
        return (m_t / DIV) % 4;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        a = 4'b1111;
        a[exp_idx()] = 1'b0;
        return a;
    endfunction

    function automatic logic [3:0] exp_digit(input logic [15:0] c, input int k, input bit blz);
        int top;
        top = 0;
        for (int j = 0; j < 4; j++) begin
            if (c[j*4 +: 4] != 4'h0) top = j;
        end
        if (blz && k > top) return 4'hF;
        return c[k*4 +: 4];
    endfunction

    task automatic check_outputs(input string tag);
        logic [3:0] ed;
        logic [3:0] ea;
        logic [1:0] ei;
        ed = exp_digit(m_cap, exp_idx(), bus.blank_lz);
        ea = exp_an();
        ei = 2'(exp_idx());
        checks++;
        assert (bus.digit_out === ed) else begin
            errors++;
            $error("FAIL %s digit_out: observed %h expected %h (t=%0d)", tag, bus.digit_out, ed, m_t);
        end
        checks++;
        assert (bus.an === ea) else begin
            errors++;
            $error("FAIL %s an: observed %b expected %b (t=%0d)", tag, bus.an, ea, m_t);
        end
        checks++;
        assert (bus.digit_idx === ei) else begin
            errors++;
            $error("FAIL %s digit_idx: observed %0d expected %0d (t=%0d)", tag, bus.digit_idx, ei, m_t);
        end
    endtask

    task automatic tick(input string tag, input bit r, input bit ld, input logic [15:0] d, input bit blz);
        rst          = r;
        bus.load     = ld;
        bus.bcd_in   = d;
        bus.blank_lz = blz;
        @(posedge clk);
        if (r) begin
            m_cap = 16'h0000;
            m_t   = 0;
        end else begin
            if (ld) m_cap = d;
            m_t++;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input string tag, input int n, input bit blz);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 1'b0, 16'h0000, blz);
    endtask

    task automatic run_until_idx(input string tag, input int k, input bit blz);
        for (int i = 0; i < 4 * DIV && exp_idx() != k; i++) tick(tag, 1'b0, 1'b0, 16'h0000, blz);
    endtask

    task automatic blank_case(input logic [15:0] v);
        tick("blank_load", 1'b1, 1'b0, 16'h0000, 1'b1);
        tick("blank_load", 1'b0, 1'b1, v, 1'b1);
        run("blank_scan", 4 * DIV, 1'b1);
    endtask

    initial begin
        logic [15:0] d;
        bit r, ld, blz;
        m_cap = 16'h0000;
        m_t = 0;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.bcd_in = 16'h0000;
        bus.blank_lz = 1'b0;

        tick("reset", 1'b1, 1'b0, 16'h0000, 1'b0);
        tick("reset", 1'b1, 1'b0, 16'h0000, 1'b0);
        checks++;
        assert (bus.an === 4'b1110 && bus.digit_out === 4'h0 && bus.digit_idx === 2'd0) else begin
            errors++;
            $error("FAIL reset_state: observed an=%b digit=%h idx=%0d expected an=1110 digit=0 idx=0",
                   bus.an, bus.digit_out, bus.digit_idx);
        end
        run("reset_dwell", DIV + 1, 1'b0);

        tick("scan", 1'b1, 1'b0, 16'h0000, 1'b0);
        tick("scan", 1'b0, 1'b1, 16'h1234, 1'b0);
        run("scan", 5 * DIV, 1'b0);

        blank_case(16'h0050);
        blank_case(16'h0000);
        blank_case(16'h0103);
        blank_case(16'hA0B9);

        blank_case(16'h0050);
        run_until_idx("blank_toggle", 3, 1'b1);
        bus.blank_lz = 1'b0;
        #1;
        check_outputs("blank_toggle_comb");
        checks++;
        assert (bus.digit_out === 4'h0) else begin
            errors++;
            $error("FAIL blank_toggle_digit3: observed %h expected 0", bus.digit_out);
        end

        tick("midload", 1'b1, 1'b0, 16'h0000, 1'b0);
        tick("midload", 1'b0, 1'b1, 16'h1234, 1'b0);
        run_until_idx("midload", 2, 1'b0);
        tick("midload", 1'b0, 1'b1, 16'h5678, 1'b0);
        checks++;
        assert (bus.digit_out === 4'h6) else begin
            errors++;
            $error("FAIL midload_digit: observed %h expected 6", bus.digit_out);
        end
        run("midload_dwell", 2 * DIV, 1'b0);

        run_until_idx("midreset", 3, 1'b0);
        for (int i = 0; i < DIV && (m_t % DIV) != 2; i++) tick("midreset", 1'b0, 1'b0, 16'h0000, 1'b0);
        tick("midreset", 1'b1, 1'b1, 16'h9999, 1'b0);
        checks++;
        assert (bus.an === 4'b1110 && bus.digit_out === 4'h0 && dut.cap === 16'h0000) else begin
            errors++;
            $error("FAIL midreset_state: observed an=%b digit=%h cap=%h expected an=1110 digit=0 cap=0000",
                   bus.an, bus.digit_out, dut.cap);
        end
        run("midreset_dwell", DIV + 1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            blz = $urandom_range(0, 1) != 0;
            for (int j = 0; j < 4; j++) d[j*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(0, 15))) : 4'h0;
            tick("random", r, ld, d, blz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
